// File: rtl/caeco_sample_ingest.sv
// CAECO ECG accelerator ingest front end: bus decode, sample FIFO with registered head, valid/ready stream out.
// Optional CAECO_INGEST_IRQ_EN adds a registered interrupt (done | ovf) mirrored in STATUS[3].
module caeco_sample_ingest #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic [1:0]        bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [7:0] CMD_CLEAR  = 8'h00;
  localparam logic [7:0] CMD_ENABLE = 8'h10;
  localparam logic [7:0] CMD_START  = 8'h11;
  localparam logic [7:0] CMD_LAST   = 8'h18;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CMD    = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [CNT_W-1:0]    r_count;
  logic                r_done;
  logic                r_ovf;
  logic                r_err;
  logic                r_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;

  logic                w_take;
  logic                w_rd;
  logic                w_cmd_wr;
  logic                w_data_wr;
  logic                w_clear;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_irq;
  state_t              w_state_n;
  logic [LW-1:0]       w_level_n;
  logic [AW-1:0]       w_rd_ptr_n;
  logic [AW-1:0]       w_wr_ptr_n;
  logic [CNT_W-1:0]    w_count_n;
  logic                w_done_n;
  logic                w_ovf_n;
  logic                w_err_n;
  logic                w_out_valid_n;
  logic                w_out_last_n;
  logic [DATA_W-1:0]   w_out_data_n;
  logic [DATA_W-1:0]   w_status;
  logic [DATA_W-1:0]   w_rdata_n;

  // A request is taken only while no acknowledge is outstanding, so a held sel never double-fires.
  assign w_take    = bus_sel & ~r_ready;
  assign w_rd      = w_take & ~bus_we;
  assign w_cmd_wr  = w_take & bus_we & (bus_addr == A_CMD);
  assign w_data_wr = w_take & bus_we & (bus_addr == A_DATA);
  assign w_clear   = w_cmd_wr & (bus_wdata == DATA_W'(CMD_CLEAR));

  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = r_out_valid & out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push = w_data_wr & (r_state == ST_STREAM) & (~w_full | w_pop);

  always_comb begin
    w_state_n  = r_state;
    w_level_n  = r_level + LW'(w_push) - LW'(w_pop);
    w_rd_ptr_n = r_rd_ptr + AW'(w_pop);
    w_wr_ptr_n = r_wr_ptr + AW'(w_push);
    w_count_n  = r_count;
    w_done_n   = r_done;
    w_ovf_n    = r_ovf;
    w_err_n    = r_err;

    if (w_push && (r_count != '1))
      w_count_n = r_count + CNT_W'(1);
    if (w_data_wr && (r_state == ST_STREAM) && w_full && !w_pop)
      w_ovf_n = 1'b1;
    if (w_data_wr && (r_state != ST_STREAM))
      w_err_n = 1'b1;

    unique case (r_state)
      ST_IDLE:   if (w_cmd_wr && (bus_wdata == DATA_W'(CMD_ENABLE))) w_state_n = ST_ARMED;
      ST_ARMED:  if (w_cmd_wr && (bus_wdata == DATA_W'(CMD_START)))  w_state_n = ST_STREAM;
      ST_STREAM: if (w_cmd_wr && (bus_wdata == DATA_W'(CMD_LAST)))   w_state_n = ST_DRAIN;
      ST_DRAIN: begin
        if (w_level_n == '0) begin
          w_state_n = ST_IDLE;
          w_done_n  = 1'b1;
        end
      end
      default:   w_state_n = ST_IDLE;
    endcase

    if (w_clear) begin
      w_state_n  = ST_IDLE;
      w_level_n  = '0;
      w_rd_ptr_n = '0;
      w_wr_ptr_n = '0;
      w_count_n  = '0;
      w_done_n   = 1'b0;
      w_ovf_n    = 1'b0;
      w_err_n    = 1'b0;
    end
  end

  // The head register is loaded with whatever entry will sit at the read pointer next cycle,
  // bypassing the array when that entry is being written right now.
  always_comb begin
    w_out_valid_n = (w_level_n != '0);
    w_out_last_n  = (w_state_n == ST_DRAIN) && (w_level_n == LW'(1));
    w_out_data_n  = r_out_data;
    if (w_out_valid_n) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_n))
        w_out_data_n = bus_wdata;
      else
        w_out_data_n = r_mem[w_rd_ptr_n];
    end
  end

  always_comb begin
    w_status       = '0;
    w_status[0]    = r_done;
    w_status[1]    = r_ovf;
    w_status[2]    = r_err;
    w_status[3]    = w_irq;
    w_status[5:4]  = r_state;
    w_status[12:8] = 5'(r_level);
  end

  always_comb begin
    w_rdata_n = '0;
    if (w_rd) begin
      unique case (bus_addr)
        A_STATUS: w_rdata_n = w_status;
        A_COUNT:  w_rdata_n = DATA_W'(r_count);
        default:  w_rdata_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= bus_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_wr_ptr    <= w_wr_ptr_n;
      r_rd_ptr    <= w_rd_ptr_n;
      r_level     <= w_level_n;
      r_count     <= w_count_n;
      r_done      <= w_done_n;
      r_ovf       <= w_ovf_n;
      r_err       <= w_err_n;
      r_ready     <= w_take;
      r_rdata     <= w_rdata_n;
      r_out_data  <= w_out_data_n;
      r_out_valid <= w_out_valid_n;
      r_out_last  <= w_out_last_n;
    end
  end

`ifdef CAECO_INGEST_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (reset)
      r_irq <= 1'b0;
    else
      r_irq <= w_done_n | w_ovf_n;
  end

  assign w_irq = r_irq;
`else
  assign w_irq = 1'b0;
`endif

  assign bus_rdata = r_rdata;
  assign bus_ready = r_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign irq       = w_irq;

endmodule

// File: tb/tb_caeco_sample_ingest.sv
// Directed bench for caeco_sample_ingest: scoreboard queue of expected beats, immediate-assertion checks.
// Builds with or without CAECO_INGEST_IRQ_EN; expected STATUS/irq values follow the same macro.
module tb_caeco_sample_ingest;

`ifdef CAECO_INGEST_IRQ_EN
  localparam logic [31:0] IRQ_BIT = 32'h0000_0008;
  localparam logic [31:0] IRQ_PIN = 32'd1;
`else
  localparam logic [31:0] IRQ_BIT = 32'h0000_0000;
  localparam logic [31:0] IRQ_PIN = 32'd0;
`endif

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CMD    = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        irq;

  int          n_asserts = 0;
  int          n_fail = 0;
  int          valid_cycles = 0;
  logic [32:0] sb_q[$];

  caeco_sample_ingest #(.DEPTH(16), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Beats are sampled mid-cycle; a beat transfers at the following rising edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1) valid_cycles++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_asserts++;
      assert (sb_q.size() > 0) else begin
        n_fail++;
        $error("FAIL beat_unexpected: observed beat 0x%08h expected no beat", out_data);
      end
      if (sb_q.size() > 0) begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("beat_data", out_data, e[31:0]);
        chk("beat_last", {31'b0, out_last}, {31'b0, e[32]});
      end
    end
  end

  task automatic bus_xfer(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
    bus_sel = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus_ready) break;
    end
    chk("bus_ack", {31'b0, bus_ready}, 32'd1);
    rd = bus_rdata;
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
    logic [31:0] unused_rd;
    bus_xfer(1'b1, addr, wd, unused_rd);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    bus_xfer(1'b0, addr, '0, v);
    chk(tag, v, exp);
  endtask

  task automatic push_data(input logic [31:0] d, input logic last, input logic expect_out);
    if (expect_out) sb_q.push_back({last, d});
    wr(A_DATA, d);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 64; k++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(tag, sb_q.size(), 32'd0);
  endtask

  initial begin
    int vc0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_last",  {31'b0, out_last},  32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_bus_ready", {31'b0, bus_ready}, 32'd0);
    chk("rst_bus_rdata", bus_rdata,          32'd0);
    chk("rst_irq",       {31'b0, irq},       32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    rd_chk("rst_status", A_STATUS, 32'h0000_0000);
    rd_chk("rst_count",  A_COUNT,  32'h0000_0000);

    // 1: three-sample record; out_ready raised after LAST so A3 is still queued in DRAIN
    wr(A_CMD, 32'h00); wr(A_CMD, 32'h10); wr(A_CMD, 32'h11);
    push_data(32'hA1, 1'b0, 1'b1);
    push_data(32'hA2, 1'b0, 1'b1);
    push_data(32'hA3, 1'b1, 1'b1);
    wr(A_CMD, 32'h18);
    out_ready = 1'b1;
    wait_drain("t1_drain");
    out_ready = 1'b0;
    rd_chk("t1_status", A_STATUS, 32'h0000_0001 | IRQ_BIT);
    rd_chk("t1_count",  A_COUNT,  32'd3);
    chk("t1_irq", {31'b0, irq}, IRQ_PIN);

    // 2: overflow with out_ready low, then drain; the 17th sample must never appear
    wr(A_CMD, 32'h00); wr(A_CMD, 32'h10); wr(A_CMD, 32'h11);
    for (int i = 0; i < 17; i++)
      push_data(32'h2000_0000 + 32'(i), 1'b0, i < 16);
    rd_chk("t2_status", A_STATUS, 32'h0000_1022 | IRQ_BIT);
    rd_chk("t2_count",  A_COUNT,  32'd16);
    chk("t2_irq", {31'b0, irq}, IRQ_PIN);
    out_ready = 1'b1;
    wait_drain("t2_drain");
    chk("t2_valid_after", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // 3: DATA in IDLE, START in IDLE, unknown CMD, STATUS write
    wr(A_CMD, 32'h00);
    vc0 = valid_cycles;
    push_data(32'h55, 1'b0, 1'b0);
    rd_chk("t3_status", A_STATUS, 32'h0000_0004);
    rd_chk("t3_count",  A_COUNT,  32'd0);
    wr(A_CMD, 32'h11);
    wr(A_CMD, 32'h42);
    wr(A_STATUS, 32'hFFFF_FFFF);
    rd_chk("t3_status2", A_STATUS, 32'h0000_0004);
    chk("t3_no_beat", 32'(valid_cycles - vc0), 32'd0);

    // 4: empty record
    wr(A_CMD, 32'h00);
    out_ready = 1'b1;
    vc0 = valid_cycles;
    wr(A_CMD, 32'h10); wr(A_CMD, 32'h11); wr(A_CMD, 32'h18);
    rd_chk("t4_status", A_STATUS, 32'h0000_0001 | IRQ_BIT);
    chk("t4_no_valid", 32'(valid_cycles - vc0), 32'd0);
    chk("t4_irq", {31'b0, irq}, IRQ_PIN);
    out_ready = 1'b0;

    // 5: full FIFO, push in the same cycle the head pops
    wr(A_CMD, 32'h00); wr(A_CMD, 32'h10); wr(A_CMD, 32'h11);
    for (int i = 0; i < 16; i++)
      push_data(32'h5000_0000 + 32'(i), 1'b0, 1'b1);
    rd_chk("t5_full_status", A_STATUS, 32'h0000_1020);
    @(posedge clk); #1;
    sb_q.push_back({1'b0, 32'h5000_00FF});
    out_ready = 1'b1;
    wr(A_DATA, 32'h5000_00FF);
    out_ready = 1'b0;
    rd_chk("t5_status", A_STATUS, 32'h0000_1020);
    rd_chk("t5_count",  A_COUNT,  32'd17);
    chk("t5_queued", sb_q.size(), 32'd16);
    out_ready = 1'b1;
    wait_drain("t5_drain");
    out_ready = 1'b0;

    // 6: reset mid-STREAM with 5 queued and done sticky from a prior record
    wr(A_CMD, 32'h00); wr(A_CMD, 32'h10); wr(A_CMD, 32'h11); wr(A_CMD, 32'h18);
    @(posedge clk); #1;
    wr(A_CMD, 32'h10); wr(A_CMD, 32'h11);
    for (int i = 0; i < 5; i++)
      push_data(32'h6000_0000 + 32'(i), 1'b0, 1'b1);
    chk("t6_irq_before", {31'b0, irq}, IRQ_PIN);
    chk("t6_valid_before", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_out_last",  {31'b0, out_last},  32'd0);
    chk("t6_irq",       {31'b0, irq},       32'd0);
    rd_chk("t6_status", A_STATUS, 32'h0000_0000);
    rd_chk("t6_count",  A_COUNT,  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
